serial_addsub: RTL and testbench

//   Digit-serial add/subtract unit, successor to the 4-bit parallel subtractor.
//   - Generalised operand width; DIGIT bits processed per clock.
//   - Selectable mode: add (a+b+cin) or subtract (a-b-bin).
//   - start/busy/done handshake; flags: carry/borrow, signed overflow, zero.
//   - Sits in the arithmetic datapath where area matters more than latency.

---
 rtl/serial_addsub.sv | 122 ++++++++++++
 tb/tb_serial_addsub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per clock, LSB-first.
// Build option: define ADDSUB_SAT_EN for signed saturation of d on overflow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             mode_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_d;
  logic             msb_cin;
  logic             ovf_next;
  logic             cout_next;
  logic             last_digit;

  // Subtraction runs as a + ~b + ~bin, so only the B slice is inverted here.
  assign a_slice = a_reg[DIGIT-1:0];
  assign b_slice = mode_reg ? ~b_reg[DIGIT-1:0] : b_reg[DIGIT-1:0];
  assign sum     = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};

  assign res_next = (res_reg >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // On the final digit the slice MSB is the word MSB; recover the carry into it.
  assign msb_cin    = a_slice[DIGIT-1] ^ b_slice[DIGIT-1] ^ sum[DIGIT-1];
  assign ovf_next   = msb_cin ^ sum[DIGIT];
  assign cout_next  = mode_reg ? ~sum[DIGIT] : sum[DIGIT];
  assign last_digit = (cnt_reg == CW'(N - 1));

`ifdef ADDSUB_SAT_EN
  // A wrapped result with MSB set means the true value overflowed positively.
  assign final_d = !ovf_next ? res_next :
                   res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} :
                                       {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign final_d = res_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      d         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      mode_reg  <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            mode_reg  <= mode;
            carry_reg <= mode ? ~cin : cin;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          res_reg   <= res_next;
          carry_reg <= sum[DIGIT];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_digit) begin
            d         <= final_d;
            cout      <= cout_next;
            ovf       <= ovf_next;
            zero      <= (final_d == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub, WIDTH=8 with DIGIT = 1, 2, 4, 8 in parallel.
// Honours ADDSUB_SAT_EN for the saturating expectations.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] cout_w;
  logic [3:0] ovf_w;
  logic [3:0] zero_w;
  logic [7:0] d_w [4];

  int n_chk;
  int n_fail;
  int first_e [4];
  int npulse [4];

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Index gi runs DIGIT = 1 << gi, so N = 8 >> gi.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    serial_addsub #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy_w[gi]),
      .done  (done_w[gi]),
      .d     (d_w[gi]),
      .cout  (cout_w[gi]),
      .ovf   (ovf_w[gi]),
      .zero  (zero_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Start one op on all DUTs, then watch edges 1..10 for done pulses.
  task automatic run_all(input logic m, input logic [7:0] aa, input logic [7:0] bb, input logic c);
    mode = m; a = aa; b = bb; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      first_e[i] = 0;
      npulse[i]  = 0;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          npulse[i]++;
          if (first_e[i] == 0) first_e[i] = k;
        end
      end
    end
  endtask

  task automatic check_dut(input string tag, input int i, input logic [7:0] ed,
                           input logic ec, input logic eo, input logic ez);
    string t;
    t = $sformatf("%s/D%0d", tag, 1 << i);
    chk({t, " done_edge"}, 32'(first_e[i]), 32'(8 >> i));
    chk({t, " done_pulses"}, 32'(npulse[i]), 32'd1);
    chk({t, " d"}, 32'(d_w[i]), 32'(ed));
    chk({t, " cout"}, 32'(cout_w[i]), 32'(ec));
    chk({t, " ovf"}, 32'(ovf_w[i]), 32'(eo));
    chk({t, " zero"}, 32'(zero_w[i]), 32'(ez));
  endtask

  task automatic run_check(input string tag, input logic m, input logic [7:0] aa,
                           input logic [7:0] bb, input logic c, input logic [7:0] ed,
                           input logic ec, input logic eo, input logic ez);
    run_all(m, aa, bb, c);
    for (int i = 0; i < 4; i++) check_dut(tag, i, ed, ec, eo, ez);
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_w[0] && n < 30);
  endtask

  // Integer reference: {zero, ovf, cout, d}.
  function automatic logic [10:0] model(input logic m, input logic [7:0] aa,
                                        input logic [7:0] bb, input logic c);
    int ua, ub, uc, sa, sb, r, s;
    logic [31:0] rr;
    logic [7:0] dd;
    logic co, ov;
    ua = int'(aa); ub = int'(bb); uc = int'(c);
    sa = int'($signed(aa)); sb = int'($signed(bb));
    if (!m) begin
      r = ua + ub + uc; co = (r > 255); s = sa + sb + uc;
    end else begin
      r = ua - ub - uc; co = (ua < ub + uc); s = sa - sb - uc;
    end
    ov = (s > 127) || (s < -128);
    rr = 32'(r);
    dd = rr[7:0];
    if (SAT && ov) dd = (s > 127) ? 8'h7F : 8'h80;
    return {(dd == 8'h00), ov, co, dd};
  endfunction

  initial begin
    int e;
    int e2;
    int k;
    bit got;
    logic [10:0] m_exp;
    logic rm, rc;
    logic [7:0] ra, rb;

    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset/D%0d busy", 1 << i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("reset/D%0d done", 1 << i), 32'(done_w[i]), 32'd0);
      chk($sformatf("reset/D%0d flags_d", 1 << i),
          {21'd0, d_w[i], cout_w[i], ovf_w[i], zero_w[i]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    run_check("sub 05-03", 1'b1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    run_check("sub 03-05", 1'b1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_check("add FF+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_check("add 7F+01", 1'b0, 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    run_check("sub 80-01", 1'b1, 8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b1, 1'b0);
    run_check("sub 10-10 bin1", 1'b1, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_check("sub 10-10 bin0", 1'b1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_check("add 12+34 cin1", 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);

    // start re-pulsed on edge 3 of a DIGIT=1 run must be ignored
    mode = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    mode = 1'b1; a = 8'h99; b = 8'h11; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 3; got = 1'b0;
    while (k < 20 && !got) begin
      tick();
      k++;
      if (done_w[0]) got = 1'b1;
    end
    chk("ignore_start done_edge", 32'(k), 32'd8);
    chk("ignore_start d", 32'(d_w[0]), 32'h46);
    chk("ignore_start cout", 32'(cout_w[0]), 32'd0);
    tick();
    chk("ignore_start done_width", 32'(done_w[0]), 32'd0);
    repeat (10) tick();

    // start held in the DONE cycle: back-to-back ops
    mode = 1'b0; a = 8'h20; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(e);
    chk("b2b first done_edge", 32'(e), 32'd8);
    chk("b2b first d", 32'(d_w[0]), 32'h42);
    mode = 1'b1; a = 8'h50; b = 8'h60; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b done_width", 32'(done_w[0]), 32'd0);
    chk("b2b busy_again", 32'(busy_w[0]), 32'd1);
    wait_done0(e2);
    chk("b2b gap", 32'(e2 + 1), 32'd9);
    chk("b2b second d", 32'(d_w[0]), 32'hF0);
    chk("b2b second cout", 32'(cout_w[0]), 32'd1);
    chk("b2b second ovf", 32'(ovf_w[0]), 32'd0);
    repeat (10) tick();

    // reset on edge 4 of a run aborts it
    mode = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy_w[0]), 32'd0);
    chk("abort done", 32'(done_w[0]), 32'd0);
    chk("abort d", 32'(d_w[0]), 32'd0);
    k = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (done_w[0]) k++;
    end
    chk("abort no_done", 32'(k), 32'd0);
    run_check("after_abort add 11+22", 1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      m_exp = model(rm, ra, rb, rc);
      run_check($sformatf("rnd%0d %s %02h,%02h,%0d", t, rm ? "sub" : "add", ra, rb, rc),
                rm, ra, rb, rc, m_exp[7:0], m_exp[8], m_exp[9], m_exp[10]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
